alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (legal range 4..32).
REQ-002 SHALL have port: clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: valid_i  input  1  request valid.
REQ-005 SHALL have port: ready_o  output  1  block can accept a request.
REQ-006 SHALL have port: data0_i  input  WIDTH  operand A (unsigned).
REQ-007 SHALL have port: data1_i  input  WIDTH  operand B (unsigned).
REQ-008 SHALL have port: ctrl_i  input  4  opcode: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 mod; all others illegal.
REQ-009 SHALL have port: valid_o  output  1  result valid.
REQ-010 SHALL have port: ready_i  input  1  consumer accepts result.
REQ-011 SHALL have port: result_o  output  WIDTH  primary result.
REQ-012 SHALL have port: result_hi_o  output  WIDTH  upper product half (see Configuration).
REQ-013 SHALL have port: carry_o  output  1  add carry-out / sub borrow.
REQ-014 SHALL have port: zero_o  output  1  result_o == 0.
REQ-015 SHALL have port: div0_o  output  1  div/mod with data1_i == 0.
REQ-016 SHALL have port: err_o  output  1  illegal opcode.

Function
REQ-017 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; ready_o = 1 only in IDLE.
REQ-018 SHALL accept a request when valid_i && ready_o, latching data0_i, data1_i, ctrl_i; later input changes SHALL NOT affect the operation.
REQ-019 Add/sub, illegal opcode, div0 SHALL skip CALC: IDLE -> DONE, valid_o asserted the cycle after acceptance (latency 1).
REQ-020 Mul SHALL use iterative shift-add, div/mod iterative restoring division, each exactly WIDTH cycles in CALC; valid_o asserted WIDTH+1 cycles after acceptance.
REQ-021 Add: result_o = (A+B) mod 2^WIDTH, carry_o = bit WIDTH of the sum; sub: result_o = (A-B) mod 2^WIDTH, carry_o = (A < B).
REQ-022 Mul: result_o = low WIDTH bits of A*B; div: result_o = floor(A/B); mod: result_o = A mod B; carry_o = 0 for mul/div/mod.
REQ-023 Div0: result_o = all ones (div) or A (mod), div0_o = 1.
REQ-024 Illegal opcode: result_o = 0, err_o = 1, zero_o = 1.
REQ-025 In DONE, valid_o and all result/flag outputs SHALL hold stable until ready_i = 1; DONE with ready_i -> IDLE next cycle, valid_o deasserts.
REQ-026 Flags div0_o, err_o SHALL be 0 for any transaction where they do not apply; zero_o evaluated on result_o only.
REQ-027 Outputs SHALL be registered; result_o, result_hi_o and flags SHALL read 0 whenever valid_o = 0.
REQ-028 Minimum issue interval SHALL be latency + 1 cycles (no acceptance while in DONE).

Reset
REQ-029 rst_ni = 0 at a rising edge SHALL force IDLE and clear all outputs: ready_o = 1 after release, valid_o = 0, result_o = 0, result_hi_o = 0, all flags 0.
REQ-030 Reset during CALC or DONE SHALL abort the operation; no valid_o for it SHALL ever appear.
REQ-031 Reset SHALL take priority over valid_i and ready_i in the same cycle.

Configuration
REQ-032 With macro ALU_ITER_MUL_HI_EN defined, mul SHALL drive result_hi_o = upper WIDTH bits of A*B; all other ops drive 0.
REQ-033 Without ALU_ITER_MUL_HI_EN, result_hi_o SHALL be constant 0 and no upper-product register SHALL be synthesised; all other behaviour identical.

Verification (WIDTH = 8)
REQ-034 SHALL cover: add 200+100 -> result_o 44, carry_o 1, valid_o 1 cycle after accept; sub 5-7 -> 254, carry_o 1.
REQ-035 SHALL cover: mul 25*12 -> result_o 44, valid_o 9 cycles after accept; result_hi_o 1 with ALU_ITER_MUL_HI_EN, 0 without.
REQ-036 SHALL cover: div 200/7 -> 28; mod 200/7 -> 4; div 9/0 -> 255, div0_o 1; mod 9/0 -> 9, div0_o 1, each latency as specified.
REQ-037 SHALL cover: opcode 0111 -> result_o 0, err_o 1, zero_o 1; then add 1+1 -> 2, err_o 0.
REQ-038 SHALL cover: ready_i held 0 for 5 cycles after valid_o -> outputs stable; data0_i toggled during CALC -> result unchanged.
REQ-039 SHALL cover: rst_ni low at CALC cycle 4 of mul -> valid_o never rises for it; next add 3+4 -> 7 correctly.

Source files
------------

// File: rtl/alu_iter.sv
// ---------------------------------------------------------------------------
// alu_iter -- iterative unsigned ALU: add, sub, mul, div and mod.
//
// Add, sub, illegal opcodes and divide-by-zero finish in one cycle. Mul runs a
// shift-add loop and div/mod run a restoring-division loop; each loop takes
// WIDTH cycles. A valid/ready handshake sits on each side. The result holds
// until the consumer accepts it, and the next request is taken only after that.
//
// Optional feature: define ALU_ITER_MUL_HI_EN to drive the upper half of the
// product on result_hi_o. Without it result_hi_o is tied to 0.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       synchronous active-low reset
//   valid_i      request valid; taken when ready_o is high
//   ready_o      high only while idle
//   data0_i      operand A (unsigned, WIDTH bits)
//   data1_i      operand B (unsigned, WIDTH bits)
//   ctrl_i       opcode 0 add, 1 sub, 2 mul, 3 div, 4 mod; others illegal
//   valid_o      result valid; held until ready_i
//   ready_i      consumer accepts the result
//   result_o     primary result (0 while valid_o is low)
//   result_hi_o  upper product half for mul (ALU_ITER_MUL_HI_EN only)
//   carry_o      add carry-out / sub borrow
//   zero_o       result_o == 0
//   div0_o       div/mod by zero
//   err_o        illegal opcode
// ---------------------------------------------------------------------------
module alu_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data0_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [3:0]       ctrl_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             div0_o,
    output logic             err_o
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;
    localparam int         CW     = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;      // multiplicand
    logic [WIDTH-1:0]  b_q, b_d;      // divisor
    logic [3:0]        op_q, op_d;
    // Shared iteration pair: mul {partial product hi, multiplier/low product},
    // div {partial remainder, dividend shifting out / quotient shifting in}.
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]  res_q, res_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic              div0_q, div0_d;
    logic              err_q, err_d;
`ifdef ALU_ITER_MUL_HI_EN
    logic [WIDTH-1:0]  res_hi_q, res_hi_d;
`endif

    // Single-cycle operations, evaluated on the incoming operands.
    logic [WIDTH:0]    add_sum;
    logic [WIDTH-1:0]  sub_diff;
    assign add_sum  = {1'b0, data0_i} + {1'b0, data1_i};
    assign sub_diff = data0_i - data1_i;

    // One shift-add step: add A when the current multiplier bit is set, then
    // shift the whole {hi, lo} pair right by one.
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH-1:0]  mul_hi_n, mul_lo_n;
    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};

    // One restoring-division step. Remainder < B, so the shifted value is
    // below 2*B and fits in WIDTH+1 bits.
    logic [WIDTH:0]    div_sh, div_diff;
    logic              div_ge;
    logic [WIDTH-1:0]  div_r_n, div_q_n;
    assign div_sh   = {hi_q, lo_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, b_q};
    assign div_ge   = (div_sh >= {1'b0, b_q});
    assign div_r_n  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_q_n  = {lo_q[WIDTH-2:0], div_ge};

    logic last;
    assign last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        div0_d  = div0_q;
        err_d   = err_q;
`ifdef ALU_ITER_MUL_HI_EN
        res_hi_d = res_hi_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Output registers are already 0 here, so only the fields an
                // opcode sets need to be written.
                if (valid_i) begin
                    a_d     = data0_i;
                    b_d     = data1_i;
                    op_d    = ctrl_i;
                    hi_d    = '0;
                    lo_d    = (ctrl_i == OP_MUL) ? data1_i : data0_i;
                    cnt_d   = '0;
                    state_d = DONE;
                    case (ctrl_i)
                        OP_ADD: begin
                            res_d   = add_sum[WIDTH-1:0];
                            carry_d = add_sum[WIDTH];
                        end
                        OP_SUB: begin
                            res_d   = sub_diff;
                            carry_d = (data0_i < data1_i);
                        end
                        OP_MUL: state_d = CALC;
                        OP_DIV, OP_MOD: begin
                            if (data1_i == '0) begin
                                div0_d = 1'b1;
                                res_d  = (ctrl_i == OP_DIV) ? '1 : data0_i;
                            end else begin
                                state_d = CALC;
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                            res_d = '0;
                        end
                    endcase
                    zero_d = (state_d == DONE) && (res_d == '0);
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (op_q == OP_MUL) begin
                    hi_d = mul_hi_n;
                    lo_d = mul_lo_n;
                end else begin
                    hi_d = div_r_n;
                    lo_d = div_q_n;
                end
                if (last) begin
                    state_d = DONE;
                    case (op_q)
                        OP_MUL: begin
                            res_d = mul_lo_n;
`ifdef ALU_ITER_MUL_HI_EN
                            res_hi_d = mul_hi_n;
`endif
                        end
                        OP_DIV:  res_d = div_q_n;
                        default: res_d = div_r_n;
                    endcase
                    zero_d = (res_d == '0);
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                    res_d   = '0;
                    carry_d = 1'b0;
                    zero_d  = 1'b0;
                    div0_d  = 1'b0;
                    err_d   = 1'b0;
`ifdef ALU_ITER_MUL_HI_EN
                    res_hi_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            div0_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ALU_ITER_MUL_HI_EN
            res_hi_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            div0_q  <= div0_d;
            err_q   <= err_d;
`ifdef ALU_ITER_MUL_HI_EN
            res_hi_q <= res_hi_d;
`endif
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = res_q;
    assign carry_o  = carry_q;
    assign zero_o   = zero_q;
    assign div0_o   = div0_q;
    assign err_o    = err_q;
`ifdef ALU_ITER_MUL_HI_EN
    assign result_hi_o = res_hi_q;
`else
    assign result_hi_o = '0;
`endif

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter (WIDTH = 8): directed cases with literal
// expectations, followed by random traffic checked every cycle against a
// transaction-level reference model.
module tb_alu_iter;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_ni, valid_i, ready_i;
    logic [W-1:0] data0_i, data1_i;
    logic [3:0]   ctrl_i;
    logic         ready_o, valid_o, carry_o, zero_o, div0_o, err_o;
    logic [W-1:0] result_o, result_hi_o;

    alu_iter #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .data0_i(data0_i), .data1_i(data1_i), .ctrl_i(ctrl_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .result_hi_o(result_hi_o), .carry_o(carry_o), .zero_o(zero_o),
        .div0_o(div0_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: what a transaction must produce, straight from the opcode rules.
    function automatic void model(input int a, input int b, input int op,
                                  output logic [19:0] o, output int lat);
        int res, hi, c, d0, e;
        res = 0; hi = 0; c = 0; d0 = 0; e = 0; lat = 1;
        case (op)
            0: begin res = (a + b) % 256; c = (a + b) > 255; end
            1: begin res = (a - b + 256) % 256; c = (a < b); end
            2: begin
                res = (a * b) % 256; lat = W + 1;
`ifdef ALU_ITER_MUL_HI_EN
                hi = (a * b) / 256;
`endif
            end
            3: if (b == 0) begin res = 255; d0 = 1; end
               else begin res = a / b; lat = W + 1; end
            4: if (b == 0) begin res = a; d0 = 1; end
               else begin res = a % b; lat = W + 1; end
            default: e = 1;
        endcase
        o = {res[7:0], hi[7:0], c[0], (res == 0), d0[0], e[0]};
    endfunction

    // Transaction-level protocol model.
    bit          m_busy = 0, m_valid = 0;
    int          m_cnt = 0;
    logic [19:0] m_out = '0;

    always @(posedge clk) begin
        int lat;
        if (!rst_ni) begin
            m_busy = 0; m_valid = 0; m_cnt = 0;
        end else if (m_valid) begin
            if (ready_i) begin m_valid = 0; m_busy = 0; end
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) m_valid = 1;
        end else if (valid_i) begin
            model(int'(data0_i), int'(data1_i), int'(ctrl_i), m_out, lat);
            m_busy = 1;
            if (lat == 1) m_valid = 1;
            else m_cnt = lat - 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready_o", ready_o, !m_busy);
            chk("valid_o", valid_o, m_valid);
            chk("outputs", {result_o, result_hi_o, carry_o, zero_o, div0_o, err_o},
                m_valid ? m_out : 20'd0);
        end
    end

    // One transaction; starts and ends just after a falling edge.
    task automatic run(input int a, input int b, input int op, input int hold,
                       output logic [19:0] o, output int lat);
        logic [19:0] cap;
        valid_i = 1; data0_i = W'(a); data1_i = W'(b); ctrl_i = 4'(op); ready_i = 0;
        @(posedge clk);
        @(negedge clk);
        valid_i = 0;
        lat = 1;
        // Scramble the operand inputs while the operation runs.
        while (!valid_o && lat < 40) begin
            data0_i = W'($urandom); data1_i = W'($urandom);
            @(negedge clk);
            lat++;
        end
        if (!valid_o) chk("timeout", 32'd0, 32'd1);
        cap = {result_o, result_hi_o, carry_o, zero_o, div0_o, err_o};
        repeat (hold) begin
            @(negedge clk);
            chk("hold", {valid_o, result_o, result_hi_o, carry_o, zero_o, div0_o, err_o},
                {1'b1, cap});
        end
        o = cap;
        ready_i = 1;
        @(negedge clk);
        ready_i = 0;
    endtask

    initial begin
        logic [19:0] o;
        int lat, v;
        logic [7:0] exp_hi;
        rst_ni = 0; valid_i = 0; ready_i = 0; data0_i = '0; data1_i = '0; ctrl_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready_o, 1);
        chk("rst_valid", valid_o, 0);
        chk("rst_outs", {result_o, result_hi_o, carry_o, zero_o, div0_o, err_o}, 0);

        // Pin the reference model on hand-computed cases.
        model(200, 100, 0, o, lat); chk("model_add", {o[19:12], o[3]}, {8'd44, 1'b1});
        model(5, 7, 1, o, lat);     chk("model_sub", {o[19:12], o[3]}, {8'd254, 1'b1});
        model(200, 7, 4, o, lat);   chk("model_mod", {o[19:12], 8'(lat)}, {8'd4, 8'd9});

        chk_en = 1;
        rst_ni = 1;
`ifdef ALU_ITER_MUL_HI_EN
        exp_hi = 8'd1;
`else
        exp_hi = 8'd0;
`endif
        // {result, hi, carry, zero, div0, err}
        run(200, 100, 0, 0, o, lat); chk("add", {o, 8'(lat)}, {8'd44, 8'd0, 4'b1000, 8'd1});
        run(5, 7, 1, 0, o, lat);     chk("sub", {o, 8'(lat)}, {8'd254, 8'd0, 4'b1000, 8'd1});
        run(25, 12, 2, 5, o, lat);   chk("mul", {o, 8'(lat)}, {8'd44, exp_hi, 4'b0000, 8'd9});
        run(200, 7, 3, 0, o, lat);   chk("div", {o, 8'(lat)}, {8'd28, 8'd0, 4'b0000, 8'd9});
        run(200, 7, 4, 0, o, lat);   chk("mod", {o, 8'(lat)}, {8'd4, 8'd0, 4'b0000, 8'd9});
        run(9, 0, 3, 0, o, lat);     chk("div0", {o, 8'(lat)}, {8'd255, 8'd0, 4'b0010, 8'd1});
        run(9, 0, 4, 2, o, lat);     chk("mod0", {o, 8'(lat)}, {8'd9, 8'd0, 4'b0010, 8'd1});
        run(1, 2, 7, 0, o, lat);     chk("illegal", {o, 8'(lat)}, {8'd0, 8'd0, 4'b0101, 8'd1});
        run(1, 1, 0, 0, o, lat);     chk("add_after_err", {o, 8'(lat)}, {8'd2, 8'd0, 4'b0000, 8'd1});
        run(255, 1, 0, 0, o, lat);   chk("add_wrap_zero", o, {8'd0, 8'd0, 4'b1100});

        // Abort a mul with reset in its fourth CALC cycle.
        valid_i = 1; data0_i = 8'd25; data1_i = 8'd12; ctrl_i = 4'd2;
        @(negedge clk);
        valid_i = 0;
        repeat (3) @(negedge clk);
        rst_ni = 0; ready_i = 1; valid_i = 1; ctrl_i = 4'd0;
        @(negedge clk);
        rst_ni = 1; ready_i = 0; valid_i = 0;
        v = 0;
        repeat (15) begin
            @(negedge clk);
            if (valid_o) v++;
        end
        chk("abort_no_valid", v, 0);
        run(3, 4, 0, 0, o, lat);     chk("add_after_rst", {o, 8'(lat)}, {8'd7, 8'd0, 4'b0000, 8'd1});

        // Random traffic; the compare process does the checking.
        for (int i = 0; i < 4000; i++) begin
            rst_ni  = ($urandom_range(0, 299) != 0);
            valid_i = ($urandom_range(0, 2) != 0);
            data0_i = W'($urandom);
            data1_i = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            v = $urandom_range(0, 11);
            ctrl_i  = (v < 10) ? 4'(v % 5) : 4'($urandom_range(5, 15));
            ready_i = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        rst_ni = 1; valid_i = 0; ready_i = 1;
        repeat (12) @(negedge clk);
        chk("drain_idle", {ready_o, valid_o}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
